// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM states, the bundle of
// pipeline-register control outputs, and the normal-flow control decode.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic back_write;
  } ctrl_t;

  // Every write enable low, no flush, no bubble: the whole pipeline holds.
  localparam ctrl_t CTRL_FREEZE = '0;

  // Flowing-pipeline decode. Load-use wins over branch because the branch
  // operands sitting in ID are not valid until the load has been forwarded.
  function automatic ctrl_t run_ctrl(input logic load_use, input logic branch_taken);
    ctrl_t c;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_bubble = 1'b0;
    c.back_write   = 1'b1;
    if (load_use) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the CPU top level and the pipeline stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 start_i;
  logic                 load_use_i;
  logic                 branch_taken_i;
  logic                 dmem_req_i;
  logic                 dmem_ack_i;
  logic                 pc_write_o;
  logic                 if_id_write_o;
  logic                 if_id_flush_o;
  logic                 id_ex_bubble_o;
  logic                 back_write_o;
  logic                 mem_err_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;

  // CPU side: drives the stall/flush/memory requests, consumes the enables.
  modport master (
    output start_i, load_use_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           back_write_o, mem_err_o, stall_cnt_o
  );

  // Controller side.
  modport slave (
    input  start_i, load_use_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           back_write_o, mem_err_o, stall_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment when enabled, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns load-use stalls, ID-stage branch flushes and
// the data-memory handshake into pipeline-register write enables, IF/ID flush
// and ID/EX bubble. Freezes the pipeline across multi-cycle memory accesses,
// flags a sticky error on memory timeout and counts stall cycles.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  ctrl_t             ctrl;
  logic              stall_en;

  // Next-state and Mealy control decode; default is a frozen pipeline.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_FREEZE;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          ctrl = run_ctrl(bus.load_use_i, bus.branch_taken_i);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          ctrl       = run_ctrl(bus.load_use_i, bus.branch_taken_i);
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d    = ST_ERROR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERROR: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and memory-wait counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Stall cycles only count while the CPU is actually executing.
  assign stall_en = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctrl.pc_write;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (stall_en),
    .cnt_o  (bus.stall_cnt_o)
  );

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.if_id_write_o  = ctrl.if_id_write;
  assign bus.if_id_flush_o  = ctrl.if_id_flush;
  assign bus.id_ex_bubble_o = ctrl.id_ex_bubble;
  assign bus.back_write_o   = ctrl.back_write;
  assign bus.mem_err_o      = (state_q == ST_ERROR);

endmodule
